series_controller_p: RTL and testbench
======================================

// Module: series_controller_p
// PURPOSE
//  Parametrised FSM sequencing a term-by-term series evaluator (x load, iterated multiply, accumulate).
//  Drives the datapath load/init/select strobes and owns the term and multiply-cycle counters internally.
//  Adds a configurable multiply depth, a per-run term count and an alternating-sign mode for sin/cos-type series.
//  Sits between the host start/ready handshake and the x/term/result register datapath.
// PARAMETERS
//  N_TERMS_MAX  8  largest term count accepted; larger requests clamp to this value
//  MULT_CYCLES  4  ldt cycles per term (>=1)
//  SEL_SPLIT    2  multiply cycles with sel=0 before sel=1 (0..MULT_CYCLES)
//  CNT_W        $clog2(N_TERMS_MAX+1)  width of n_terms and term_idx
// PORTS
//  clk       in   1      rising-edge clock
//  rst       in   1      asynchronous, active-low reset
//  start     in   1      run request; sampled in IDLE
//  n_terms   in   CNT_W  terms to evaluate; latched in INIT
//  alt_sign  in   1      1 = alternate add/sub per term; latched in INIT
//  ready     out  1      1 only in IDLE
//  busy      out  1      1 in every state except IDLE
//  done      out  1      one-cycle pulse in DONE
//  ldx       out  1      load x register
//  initt     out  1      initialise term register
//  ldt       out  1      load term register (multiply step)
//  sel       out  1      multiplier operand select
//  initr     out  1      initialise result register
//  ldr       out  1      load result register (accumulate)
//  add_sub   out  1      1 = add, 0 = subtract; valid while ldr=1, 1 otherwise
//  term_idx  out  CNT_W  0-based index of the current term
// BEHAVIOUR
//  All outputs are Moore, decoded from state and counters only.
//  Reset (rst=0): asynchronously enter IDLE with mcnt=0 and tcnt=0.
//    Outputs: ready=1, add_sub=1, all others 0. Applies mid-run too; no residual strobes.
//  States and transitions:
//  IDLE:  ready=1. If start=1, go to INIT; else stay in IDLE.
//  INIT:  initt=initr=1; latch lim=clamp(n_terms) and alt_sign.
//    clamp: 0 -> 1; >N_TERMS_MAX -> N_TERMS_MAX.
//    Stay in INIT while start=1; go to LOAD on the first cycle with start=0.
//  LOAD:  ldx=1 for 1 cycle; tcnt=0, mcnt=0; go to MULT.
//  MULT:  ldt=1 for exactly MULT_CYCLES cycles; mcnt counts 0..MULT_CYCLES-1.
//    sel=(mcnt>=SEL_SPLIT). At the last mcnt, go to ACCUM with mcnt back to 0.
//  ACCUM: ldr=1 for 1 cycle; add_sub = ~(alt_sign & tcnt[0]).
//    If tcnt==lim-1, go to DONE; else tcnt++ and go to MULT.
//  DONE:  done=1 for 1 cycle; go to IDLE. ready rises on the following cycle.
//  term_idx=tcnt, held through ACCUM of that term; 0 in IDLE, INIT and LOAD.
//  start is ignored in every state except IDLE and INIT (no restart, no abort).
//  Latency: from the INIT exit edge, done is high at cycle 1 + lim*(MULT_CYCLES+1) + 1.
//    That is: LOAD, then the terms, then DONE.
//  Counters never wrap: tcnt<=N_TERMS_MAX-1 and mcnt<=MULT_CYCLES-1 by construction.
//  Unused state encodings go to IDLE on the next clock.
// TESTING  (defaults: MULT_CYCLES=4, SEL_SPLIT=2, N_TERMS_MAX=8)
//  Reset: rst=0 for 2 cycles, checked mid-ACCUM too -> ready=1, add_sub=1, all other outputs 0 immediately.
//  start 1 cycle, n_terms=3, alt_sign=0 -> INIT 1, LOAD 1, then 3x(ldt x4 with sel 0,0,1,1; ldr x1).
//    Then done 1 cycle, 18 cycles after INIT entry; add_sub=1 on every ldr.
//  alt_sign=1, n_terms=4 -> add_sub on the four ldr pulses = 1,0,1,0; term_idx = 0,1,2,3.
//  start held 5 cycles -> INIT held 5 cycles with initt=initr=1; ldx exactly 1 cycle after start falls.
//  n_terms=0 -> exactly 1 ldr pulse; n_terms=15 -> exactly 8 ldr pulses.
//  start pulsed during MULT/DONE -> ignored.
//  rst low in MULT of term 2 -> IDLE at once; after release, a new start runs a full sequence from term_idx=0.

Source files
------------

// File: rtl/series_controller_p_if.sv
// Host/datapath-facing signal bundle for series_controller_p.
//   master : the host side. It drives start, n_terms and alt_sign, and
//            observes the status and strobe outputs.
//   slave  : the controller side. It samples the host request and drives
//            ready, busy and done, the datapath strobes, add_sub and term_idx.
//   CNT_W  : width of n_terms and term_idx. It must match the controller's
//            CNT_W.
interface series_controller_p_if #(
    parameter int CNT_W = 4
);
    logic             start;
    logic [CNT_W-1:0] n_terms;
    logic             alt_sign;
    logic             ready;
    logic             busy;
    logic             done;
    logic             ldx;
    logic             initt;
    logic             ldt;
    logic             sel;
    logic             initr;
    logic             ldr;
    logic             add_sub;
    logic [CNT_W-1:0] term_idx;

    modport master (
        output start, n_terms, alt_sign,
        input  ready, busy, done, ldx, initt, ldt, sel, initr, ldr, add_sub, term_idx
    );

    modport slave (
        input  start, n_terms, alt_sign,
        output ready, busy, done, ldx, initt, ldt, sel, initr, ldr, add_sub, term_idx
    );
endinterface

// File: rtl/series_controller_p.sv
// Sequencer for a term-by-term series evaluator.
// The run goes: load x, then for each term iterate the multiply for
// MULT_CYCLES cycles, then accumulate the term into the result with add or
// subtract. The controller owns the term counter (tcnt) and the
// multiply-cycle counter (mcnt). Every output is Moore, decoded from the
// state and the counters.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous reset, active low
//   bus  : series_controller_p_if.slave. It carries:
//            - the host handshake: start, ready, busy, done
//            - the run configuration: n_terms, alt_sign
//            - the datapath strobes: ldx, initt, ldt, sel, initr, ldr, add_sub
//            - the current term index: term_idx
module series_controller_p #(
    parameter int N_TERMS_MAX = 8,
    parameter int MULT_CYCLES = 4,
    parameter int SEL_SPLIT   = 2,
    parameter int CNT_W       = $clog2(N_TERMS_MAX + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    series_controller_p_if.slave  bus
);

    localparam int MCNT_W = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;
    localparam logic [MCNT_W-1:0] MCNT_LAST = MCNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  LIM_MAX   = CNT_W'(N_TERMS_MAX);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_LOAD  = 3'd2,
        S_MULT  = 3'd3,
        S_ACCUM = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t            state_reg, state_next;
    logic [MCNT_W-1:0] mcnt_reg, mcnt_next;
    logic [CNT_W-1:0]  tcnt_reg, tcnt_next;
    logic [CNT_W-1:0]  lim_reg, lim_next;
    logic              alt_reg, alt_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
            mcnt_reg  <= '0;
            tcnt_reg  <= '0;
            lim_reg   <= CNT_W'(1);
            alt_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            mcnt_reg  <= mcnt_next;
            tcnt_reg  <= tcnt_next;
            lim_reg   <= lim_next;
            alt_reg   <= alt_next;
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_next = state_reg;
        mcnt_next  = mcnt_reg;
        tcnt_next  = tcnt_reg;
        lim_next   = lim_reg;
        alt_next   = alt_reg;
        case (state_reg)
            S_IDLE: begin
                mcnt_next = '0;
                tcnt_next = '0;
                if (bus.start) state_next = S_INIT;
            end
            S_INIT: begin
                // Re-latch on every INIT cycle, so the value present on the
                // exit cycle is the one the run uses. A request for zero
                // terms still evaluates one term.
                if (bus.n_terms == '0)
                    lim_next = CNT_W'(1);
                else if (32'(bus.n_terms) > N_TERMS_MAX)
                    lim_next = LIM_MAX;
                else
                    lim_next = bus.n_terms;
                alt_next = bus.alt_sign;
                if (!bus.start) state_next = S_LOAD;
            end
            S_LOAD: begin
                mcnt_next  = '0;
                tcnt_next  = '0;
                state_next = S_MULT;
            end
            S_MULT: begin
                if (mcnt_reg == MCNT_LAST) begin
                    mcnt_next  = '0;
                    state_next = S_ACCUM;
                end else begin
                    mcnt_next = mcnt_reg + MCNT_W'(1);
                end
            end
            S_ACCUM: begin
                if (tcnt_reg == lim_reg - CNT_W'(1)) begin
                    state_next = S_DONE;
                end else begin
                    tcnt_next  = tcnt_reg + CNT_W'(1);
                    state_next = S_MULT;
                end
            end
            S_DONE: begin
                // Clear here so term_idx reads 0 as soon as IDLE is entered.
                tcnt_next  = '0;
                state_next = S_IDLE;
            end
            default: begin
                mcnt_next  = '0;
                tcnt_next  = '0;
                state_next = S_IDLE;
            end
        endcase
    end

    // Moore output decode
    always_comb begin
        bus.ready    = 1'b0;
        bus.busy     = 1'b1;
        bus.done     = 1'b0;
        bus.ldx      = 1'b0;
        bus.initt    = 1'b0;
        bus.ldt      = 1'b0;
        bus.sel      = 1'b0;
        bus.initr    = 1'b0;
        bus.ldr      = 1'b0;
        bus.add_sub  = 1'b1;
        bus.term_idx = tcnt_reg;
        case (state_reg)
            S_IDLE: begin
                bus.ready = 1'b1;
                bus.busy  = 1'b0;
            end
            S_INIT: begin
                bus.initt = 1'b1;
                bus.initr = 1'b1;
            end
            S_LOAD:  bus.ldx = 1'b1;
            S_MULT: begin
                bus.ldt = 1'b1;
                bus.sel = (32'(mcnt_reg) >= SEL_SPLIT);
            end
            S_ACCUM: begin
                bus.ldr     = 1'b1;
                bus.add_sub = ~(alt_reg & tcnt_reg[0]);
            end
            S_DONE:  bus.done = 1'b1;
            default: begin
                bus.busy = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_series_controller_p.sv
module tb_series_controller_p;

    logic clk;
    logic rst;

    series_controller_p_if #(.CNT_W(4)) bus ();

    series_controller_p #(
        .N_TERMS_MAX (8),
        .MULT_CYCLES (4),
        .SEL_SPLIT   (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nbad = 0;

    // Output vector layout:
    // {ready, busy, done, ldx, initt, ldt, sel, initr, ldr, add_sub, term_idx[3:0]}
    logic [13:0] outs;
    assign outs = {bus.ready, bus.busy, bus.done, bus.ldx, bus.initt, bus.ldt,
                   bus.sel, bus.initr, bus.ldr, bus.add_sub, bus.term_idx};

    localparam logic [13:0] ALL    = 14'h3FFF;
    localparam logic [13:0] NO_IDX = 14'h3FF0;

    function automatic logic [13:0] ev(input bit rdy, input bit bsy, input bit dn,
                                       input bit lx, input bit it, input bit lt,
                                       input bit sl, input bit ir, input bit lr,
                                       input bit as, input int idx);
        return {rdy, bsy, dn, lx, it, lt, sl, ir, lr, as, 4'(idx)};
    endfunction

    task automatic check(input string name, input logic [13:0] exp, input logic [13:0] mask);
        nvec++;
        if ((outs & mask) !== (exp & mask)) begin
            nbad++;
            $display("FAIL %s: got %h want %h", name, outs & mask, exp & mask);
        end
    endtask

    // Scoreboard of expected accumulate pulses
    typedef struct {
        bit         add_sub;
        logic [3:0] idx;
    } sb_t;
    sb_t sb_q[$];
    bit  sb_en = 1'b0;

    always @(negedge clk) begin
        if (sb_en && rst && bus.ldr) begin
            nvec++;
            if (sb_q.size() == 0) begin
                nbad++;
                $display("FAIL sb_unexpected_ldr: got ldr at idx %0d want no ldr", bus.term_idx);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                if (bus.add_sub !== e.add_sub || bus.term_idx !== e.idx) begin
                    nbad++;
                    $display("FAIL sb_ldr: got add_sub=%0b idx=%0d want add_sub=%0b idx=%0d",
                             bus.add_sub, bus.term_idx, e.add_sub, e.idx);
                end
            end
        end
    end

    typedef struct {
        int n;
        bit alt;
        int hold;
        bit poke;
    } vec_t;

    // The task is entered and left at a negedge while the DUT is in IDLE.
    task automatic run(input int n, input bit alt, input int hold, input bit poke);
        int lim;
        lim = (n == 0) ? 1 : ((n > 8) ? 8 : n);
        $display("run n_terms=%0d alt=%0b hold=%0d poke=%0b lim=%0d", n, alt, hold, poke, lim);
        check($sformatf("idle_pre n=%0d", n), ev(1,0,0,0,0,0,0,0,0,1,0), ALL);
        for (int k = 0; k < lim; k++) begin
            sb_t e;
            e.add_sub = !(alt && k[0]);
            e.idx     = 4'(k);
            sb_q.push_back(e);
        end
        bus.start    = 1'b1;
        bus.n_terms  = 4'(n);
        bus.alt_sign = alt;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check($sformatf("init n=%0d h=%0d", n, h), ev(0,1,0,0,1,0,0,1,0,1,0), ALL);
            if (h == hold - 1) bus.start = 1'b0;
        end
        @(negedge clk);
        check($sformatf("load n=%0d", n), ev(0,1,0,1,0,0,0,0,0,1,0), ALL);
        for (int t = 0; t < lim; t++) begin
            for (int m = 0; m < 4; m++) begin
                @(negedge clk);
                check($sformatf("mult n=%0d t=%0d m=%0d", n, t, m),
                      ev(0,1,0,0,0,1,(m >= 2),0,0,1,t), ALL);
                if (poke && t == 0) bus.start = (m == 1);
            end
            @(negedge clk);
            check($sformatf("accum n=%0d t=%0d", n, t),
                  ev(0,1,0,0,0,0,0,0,1,!(alt && t[0]),t), ALL);
        end
        @(negedge clk);
        check($sformatf("done n=%0d", n), ev(0,1,1,0,0,0,0,0,0,1,0), NO_IDX);
        if (poke) bus.start = 1'b1;
        @(negedge clk);
        check($sformatf("idle_post n=%0d", n), ev(1,0,0,0,0,0,0,0,0,1,0), ALL);
        bus.start = 1'b0;
        @(negedge clk);
        check($sformatf("idle_stay n=%0d", n), ev(1,0,0,0,0,0,0,0,0,1,0), ALL);
        nvec++;
        if (sb_q.size() != 0) begin
            nbad++;
            $display("FAIL sb_leftover n=%0d: got %0d pending ldr want 0", n, sb_q.size());
            sb_q.delete();
        end
    endtask

    // Starts a one-cycle-start run and advances nedges negedges into it.
    task automatic start_partial(input int n, input int nedges);
        check("idle_partial", ev(1,0,0,0,0,0,0,0,0,1,0), ALL);
        bus.start    = 1'b1;
        bus.n_terms  = 4'(n);
        bus.alt_sign = 1'b0;
        for (int k = 1; k <= nedges; k++) begin
            @(negedge clk);
            if (k == 1) bus.start = 1'b0;
        end
    endtask

    task automatic reset_now(input string tag);
        #1 rst = 1'b0;
        #1 check($sformatf("rst_async %s", tag), ev(1,0,0,0,0,0,0,0,0,1,0), ALL);
        @(negedge clk);
        check($sformatf("rst_hold1 %s", tag), ev(1,0,0,0,0,0,0,0,0,1,0), ALL);
        @(negedge clk);
        check($sformatf("rst_hold2 %s", tag), ev(1,0,0,0,0,0,0,0,0,1,0), ALL);
        rst = 1'b1;
        @(negedge clk);
        check($sformatf("rst_release %s", tag), ev(1,0,0,0,0,0,0,0,0,1,0), ALL);
    endtask

    vec_t tbl[8];

    initial begin
        tbl[0] = '{3,  1'b0, 1, 1'b0};
        tbl[1] = '{4,  1'b1, 1, 1'b0};
        tbl[2] = '{3,  1'b0, 5, 1'b0};
        tbl[3] = '{0,  1'b0, 1, 1'b0};
        tbl[4] = '{15, 1'b1, 1, 1'b0};
        tbl[5] = '{8,  1'b1, 1, 1'b1};
        tbl[6] = '{1,  1'b1, 2, 1'b0};
        tbl[7] = '{7,  1'b1, 1, 1'b0};

        rst          = 1'b0;
        bus.start    = 1'b0;
        bus.n_terms  = '0;
        bus.alt_sign = 1'b0;

        // Power-on reset held for two cycles
        @(negedge clk);
        check("por_cycle1", ev(1,0,0,0,0,0,0,0,0,1,0), ALL);
        @(negedge clk);
        check("por_cycle2", ev(1,0,0,0,0,0,0,0,0,1,0), ALL);
        rst = 1'b1;
        @(negedge clk);
        check("por_release", ev(1,0,0,0,0,0,0,0,0,1,0), ALL);

        sb_en = 1'b1;
        for (int i = 0; i < 8; i++)
            run(tbl[i].n, tbl[i].alt, tbl[i].hold, tbl[i].poke);

        // Reset while the second term is accumulating
        sb_en = 1'b0;
        $display("seq reset_mid_accum");
        start_partial(3, 12);
        check("pre_rst_accum_t1", ev(0,1,0,0,0,0,0,0,1,1,1), ALL);
        reset_now("accum");

        // Reset in the multiply of term 2, then a full rerun from term 0
        $display("seq reset_mid_mult");
        start_partial(3, 14);
        check("pre_rst_mult_t2", ev(0,1,0,0,0,1,0,0,0,1,2), ALL);
        reset_now("mult");
        sb_q.delete();
        sb_en = 1'b1;
        run(3, 1'b0, 1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
